slice_scheduler: RTL and testbench
==================================

# slice_scheduler

Round-robin time-slice scheduler that shares one modulo-K slot counter among N requesters. Grants the counter to one requester at a time for at most K enabled cycles, then rotates to the next pending requester. Sits in front of the modulo counter datapath as its sequencing and arbitration layer, and exposes the running slot count to the current owner.

## Interface
- `N`, default 4: number of requesters; N >= 2.
- `K`, default 16: slice length in enabled cycles; K >= 1.
- `W`, default 32: width of `count`.
- `IW`, default 2: width of `owner`; must equal clog2(N).

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset. Low clears all state immediately, independent of `clk`.
- `enable`  in  1: global run enable. 0 freezes all state.
- `req`  in  N: request per requester, level-sensitive.
- `grant`  out  N: one-hot grant, registered; all zero when idle.
- `owner`  out  IW: index of the granted requester; 0 when idle.
- `busy`  out  1: 1 while in RUN.
- `count`  out  W: slot count 0..K-1 of the current slice; 0 when idle.
- `slice_done`  out  1: one-cycle pulse marking a fully completed slice.

## Operation
- State: FSM {IDLE, RUN}, plus the round-robin pointer `ptr` (0..N-1) and `count`.
- Reset (`reset`=0): state=IDLE, `grant`=0, `owner`=0, `busy`=0, `count`=0, `slice_done`=0, `ptr`=0.
- `enable`=0: state, `ptr`, `count`, `grant` and `owner` all hold. `req` is ignored. `slice_done` is 0.
- Arbitration: pick the first i with `req[i]`=1, scanning `ptr`, `ptr`+1, … mod N.
- IDLE with `enable`=1 and `req`≠0:
  - next state RUN; `grant`=onehot(i), `owner`=i, `count`=0.
- IDLE with `enable`=1 and `req`=0: stay IDLE.
- RUN with `enable`=1, classified in priority order:
  1. Early release, when `req[owner]`=0: end the slice with `slice_done`=0.
  2. Slice end, when `count`=K-1 and `req[owner]`=1: end the slice with `slice_done`=1.
  3. Otherwise: `count` increments by 1.
- End of slice:
  - `ptr` = (`owner`+1) mod N, so the previous owner gets lowest priority.
  - `count`=0.
  - Re-arbitrate in the same edge using the new `ptr`. If some `req` is set, grant it and stay in RUN with no idle gap; this may re-grant the same owner if it is the only requester. If no `req` is set, go to IDLE with `grant`=0.
- `grant` is always zero or exactly one-hot. `owner` is consistent with `grant`. `busy`=|`grant`.
- Simultaneous early release and count=K-1: this is an early release; `slice_done`=0.
- K=1: every enabled RUN cycle with `req[owner]`=1 is a slice end; `count` stays 0.
- `reset` asserted mid-slice: outputs clear asynchronously. After release, arbitration restarts from `ptr`=0.

## Timing
- `req` is sampled on the rising edge. `grant` appears 1 cycle after `req` is seen in IDLE.
- A full slice holds `grant` for exactly K enabled cycles, with `count` showing 0..K-1.
- `slice_done` is registered. It is high for the one cycle following the edge that ends the slice, which is the first cycle of the next grant or of IDLE.
- Early release: `grant` drops or moves at the first edge where `req[owner]`=0 is sampled.
- Cycles with `enable`=0 extend the slice without advancing `count`.

## Test plan
- Reset and idle: hold `reset`=0, then release with `req`=0, `enable`=1. All outputs stay 0 for 20 cycles.
- Single requester, K=16: `req`=4'b0001 held.
  - `grant`=0001 is asserted 1 cycle later.
  - `count` runs 0..15.
  - `slice_done` pulses after cycle 16.
  - The same requester is re-granted with no gap and `count` restarts at 0.
- Round robin: `req`=4'b1011 held.
  - Grant order is 0, 1, 3, 0, …, each slice 16 cycles.
  - There is one `slice_done` pulse per switch.
  - `grant` is never zero between slices.
- Early release: requester 2 drops `req` at `count`=5.
  - `grant` moves at the next edge.
  - `slice_done`=0.
  - The next owner starts at `count`=0.
  - `ptr`=3.
- Pause: drop `enable` for 7 cycles at `count`=9.
  - `count` holds at 9 and `grant` holds.
  - The slice completes after 16 enabled cycles, i.e. 23 total.
- Async reset mid-slice: pull `reset` low between clock edges at `count`=10.
  - `grant`, `count` and `busy` go to 0 without a clock edge.
  - After release with `req`=4'b1100, `grant`=0100.

Source files
------------

// File: rtl/slice_scheduler.sv
// Round-robin time-slice scheduler: lends one modulo-K slot counter to N requesters,
// one owner at a time, for at most K enabled cycles per slice.
module slice_scheduler #(
   parameter int N  = 4,
   parameter int K  = 16,
   parameter int W  = 32,
   parameter int IW = 2
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_enable,
   input  logic [N-1:0]  i_req,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_owner,
   output logic          o_busy,
   output logic [W-1:0]  o_count,
   output logic          o_slice_done
);

   localparam logic [0:0]    S_IDLE   = 1'b0;
   localparam logic [0:0]    S_RUN    = 1'b1;
   localparam logic [W-1:0]  LAST     = W'(K - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
   localparam logic [IW:0]   N_WIDE   = (IW + 1)'(N);

   logic [0:0]    r_state;
   logic [IW-1:0] r_ptr;
   logic [IW-1:0] r_owner;
   logic [N-1:0]  r_grant;
   logic [W-1:0]  r_count;
   logic          r_slice_done;

   logic [IW-1:0] w_owner_succ;
   logic [IW-1:0] w_arb_base;
   logic          w_owner_req;
   logic          w_slice_end;
   logic          w_pick_valid;
   logic [IW-1:0] w_pick_idx;
   logic [IW:0]   w_sum;

   assign w_owner_succ = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
   // At a slice end the new pointer is used in the same edge, so arbitrate from it directly.
   assign w_arb_base   = (r_state == S_RUN) ? w_owner_succ : r_ptr;
   assign w_owner_req  = i_req[r_owner];
   assign w_slice_end  = !w_owner_req || (r_count == LAST);

   // Scan from the farthest offset down so the offset nearest the base wins.
   always_comb begin
      w_pick_valid = 1'b0;
      w_pick_idx   = '0;
      w_sum        = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_sum = {1'b0, w_arb_base} + (IW + 1)'(k);
         if (w_sum >= N_WIDE)
            w_sum = w_sum - N_WIDE;
         if (i_req[w_sum[IW-1:0]]) begin
            w_pick_valid = 1'b1;
            w_pick_idx   = w_sum[IW-1:0];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_owner      <= '0;
         r_grant      <= '0;
         r_count      <= '0;
         r_slice_done <= 1'b0;
      end else begin
         r_slice_done <= 1'b0;
         if (i_enable) begin
            if (r_state == S_IDLE) begin
               if (w_pick_valid) begin
                  r_state <= S_RUN;
                  r_grant <= N'(1) << w_pick_idx;
                  r_owner <= w_pick_idx;
                  r_count <= '0;
               end
            end else if (w_slice_end) begin
               // Early release takes priority, so a full slice is only flagged while still requested.
               r_slice_done <= w_owner_req;
               r_ptr        <= w_owner_succ;
               r_count      <= '0;
               if (w_pick_valid) begin
                  r_grant <= N'(1) << w_pick_idx;
                  r_owner <= w_pick_idx;
               end else begin
                  r_state <= S_IDLE;
                  r_grant <= '0;
                  r_owner <= '0;
               end
            end else begin
               r_count <= r_count + 1'b1;
            end
         end
      end
   end

   assign o_grant      = r_grant;
   assign o_owner      = r_owner;
   assign o_busy       = |r_grant;
   assign o_count      = r_count;
   assign o_slice_done = r_slice_done;

endmodule

// File: tb/tb_slice_scheduler.sv
// Directed bench for slice_scheduler with N=4, K=16: reset, full slices, rotation,
// early release, pause and asynchronous reset.
module tb_slice_scheduler;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [3:0]  req;
   logic [3:0]  grant;
   logic [1:0]  owner;
   logic        busy;
   logic [31:0] count;
   logic        slice_done;

   int checks;
   int failures;

   slice_scheduler #(.N(4), .K(16), .W(32), .IW(2)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_enable     (enable),
      .i_req        (req),
      .o_grant      (grant),
      .o_owner      (owner),
      .o_busy       (busy),
      .o_count      (count),
      .o_slice_done (slice_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n  = 1'b0;
      enable = 1'b1;
      req    = 4'b0000;
      #3;
      rst_n  = 1'b1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      enable = 1'b1;
      req    = 4'b0000;
      tick();
      tick();
      checks++;
      if ({grant, owner, busy, count, slice_done} !== 40'd0) begin
         failures++;
         $display("FAIL reset_hold: grant=%b owner=%0d busy=%b count=%0d done=%b, want all 0",
                  grant, owner, busy, count, slice_done);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         checks++;
         if ({grant, owner, busy, count, slice_done} !== 40'd0) begin
            failures++;
            $display("FAIL idle_cycle%0d: grant=%b owner=%0d busy=%b count=%0d done=%b, want all 0",
                     c, grant, owner, busy, count, slice_done);
         end
      end
      $display("test_reset done: checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_single();
      apply_reset();
      req = 4'b0001;
      tick();
      for (int c = 0; c < 16; c++) begin
         checks++;
         if (grant !== 4'b0001 || owner !== 2'd0 || busy !== 1'b1 || count !== 32'(c) || slice_done !== 1'b0) begin
            failures++;
            $display("FAIL single_c%0d: grant=%b owner=%0d busy=%b count=%0d done=%b, want 0001/0/1/%0d/0",
                     c, grant, owner, busy, count, slice_done, c);
         end
         tick();
      end
      checks++;
      if (grant !== 4'b0001 || count !== 32'd0 || slice_done !== 1'b1) begin
         failures++;
         $display("FAIL single_regrant: grant=%b count=%0d done=%b, want 0001/0/1", grant, count, slice_done);
      end
      tick();
      checks++;
      if (grant !== 4'b0001 || count !== 32'd1 || slice_done !== 1'b0) begin
         failures++;
         $display("FAIL single_second: grant=%b count=%0d done=%b, want 0001/1/0", grant, count, slice_done);
      end
      req = 4'b0000;
      tick();
      checks++;
      if (grant !== 4'b0000 || owner !== 2'd0 || busy !== 1'b0 || count !== 32'd0 || slice_done !== 1'b0) begin
         failures++;
         $display("FAIL single_to_idle: grant=%b owner=%0d busy=%b count=%0d done=%b, want all 0",
                  grant, owner, busy, count, slice_done);
      end
      $display("test_single done: checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_round_robin();
      logic [1:0] order [5];
      order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd3; order[3] = 2'd0; order[4] = 2'd1;
      apply_reset();
      req = 4'b1011;
      tick();
      for (int s = 0; s < 5; s++) begin
         for (int c = 0; c < 16; c++) begin
            checks++;
            if (grant !== (4'b0001 << order[s]) || owner !== order[s] || count !== 32'(c)
                || slice_done !== (c == 0 && s > 0)) begin
               failures++;
               $display("FAIL rr_s%0d_c%0d: grant=%b owner=%0d count=%0d done=%b, want owner %0d count %0d done %0d",
                        s, c, grant, owner, count, slice_done, order[s], c, (c == 0 && s > 0));
            end
            tick();
         end
      end
      $display("test_round_robin done: checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_early_release();
      apply_reset();
      req = 4'b0100;
      tick();
      for (int c = 0; c < 5; c++) tick();
      checks++;
      if (grant !== 4'b0100 || count !== 32'd5) begin
         failures++;
         $display("FAIL er_setup: grant=%b count=%0d, want 0100/5", grant, count);
      end
      // Requester 2 drops; pointer becomes 3 so requester 3 beats requester 1.
      req = 4'b1010;
      tick();
      checks++;
      if (grant !== 4'b1000 || owner !== 2'd3 || count !== 32'd0 || slice_done !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL er_move: grant=%b owner=%0d count=%0d done=%b busy=%b, want 1000/3/0/0/1",
                  grant, owner, count, slice_done, busy);
      end
      for (int c = 0; c < 15; c++) tick();
      checks++;
      if (grant !== 4'b1000 || count !== 32'd15) begin
         failures++;
         $display("FAIL er_last_setup: grant=%b count=%0d, want 1000/15", grant, count);
      end
      // Release coinciding with the last slot is still an early release.
      req = 4'b0010;
      tick();
      checks++;
      if (grant !== 4'b0010 || owner !== 2'd1 || count !== 32'd0 || slice_done !== 1'b0) begin
         failures++;
         $display("FAIL er_at_last: grant=%b owner=%0d count=%0d done=%b, want 0010/1/0/0",
                  grant, owner, count, slice_done);
      end
      $display("test_early_release done: checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_pause();
      apply_reset();
      req = 4'b0001;
      tick();
      for (int c = 0; c < 9; c++) tick();
      enable = 1'b0;
      req    = 4'b0000;
      for (int c = 0; c < 7; c++) begin
         tick();
         checks++;
         if (grant !== 4'b0001 || count !== 32'd9 || slice_done !== 1'b0) begin
            failures++;
            $display("FAIL pause_hold%0d: grant=%b count=%0d done=%b, want 0001/9/0", c, grant, count, slice_done);
         end
      end
      req    = 4'b0001;
      enable = 1'b1;
      for (int c = 0; c < 6; c++) tick();
      checks++;
      if (grant !== 4'b0001 || count !== 32'd15 || slice_done !== 1'b0) begin
         failures++;
         $display("FAIL pause_last: grant=%b count=%0d done=%b, want 0001/15/0", grant, count, slice_done);
      end
      tick();
      checks++;
      if (grant !== 4'b0001 || count !== 32'd0 || slice_done !== 1'b1) begin
         failures++;
         $display("FAIL pause_end: grant=%b count=%0d done=%b, want 0001/0/1", grant, count, slice_done);
      end
      $display("test_pause done: checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_async_reset();
      apply_reset();
      req = 4'b0001;
      tick();
      for (int c = 0; c < 10; c++) tick();
      checks++;
      if (count !== 32'd10 || grant !== 4'b0001) begin
         failures++;
         $display("FAIL ar_setup: grant=%b count=%0d, want 0001/10", grant, count);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (grant !== 4'b0000 || count !== 32'd0 || busy !== 1'b0 || owner !== 2'd0) begin
         failures++;
         $display("FAIL ar_clear: grant=%b count=%0d busy=%b owner=%0d, want all 0", grant, count, busy, owner);
      end
      req = 4'b1100;
      #1;
      rst_n = 1'b1;
      tick();
      checks++;
      if (grant !== 4'b0100 || owner !== 2'd2 || count !== 32'd0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL ar_restart: grant=%b owner=%0d count=%0d busy=%b, want 0100/2/0/1",
                  grant, owner, count, busy);
      end
      $display("test_async_reset done: checks=%0d failures=%0d", checks, failures);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      enable   = 1'b0;
      req      = 4'b0000;
      test_reset();
      test_single();
      test_round_robin();
      test_early_release();
      test_pause();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
